// File: rtl/tile_seq.sv
// Weight-stationary tile sequencer: expands one start request into the full
// weight-load, activation-stream and psum-drain instruction sequence for core.
module tile_seq #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int aw  = 11,
  parameter int tmo = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [aw-1:0]    w_base,
  input  logic [aw-1:0]    x_base,
  input  logic [aw-1:0]    p_base,
  input  logic [6:0]       n_x,
  input  logic             acc_cfg,
  input  logic             ofifo_valid,
  output logic [2*aw+12:0] inst,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int         IW    = $clog2(tmo + 1);
  localparam logic [6:0] N_MAX = 7'd64;

  // Counters are 7 bits wide and addresses are zero-extended into aw bits.
  if (col < 1 || col > 64 || row < 1 || aw < 7) begin : g_bad_params
    $error("tile_seq: unsupported parameter set");
  end

  typedef enum logic [3:0] {
    IDLE, W_RD, W_FL, W_LD, W_GAP, X_RD, X_FL, X_EX, OUT, DONE
  } state_t;

  typedef struct packed {
    logic          mode_os;
    logic          acc;
    logic          cen_pmem;
    logic          wen_pmem;
    logic [aw-1:0] a_pmem;
    logic          cen_xmem;
    logic          wen_xmem;
    logic [aw-1:0] a_xmem;
    logic          ofifo_rd;
    logic          ififo_wr;
    logic          ififo_rd;
    logic          l0_rd;
    logic          l0_wr;
    logic          execute;
    logic          load;
  } inst_t;

  typedef struct packed {
    logic [aw-1:0] w_base;
    logic [aw-1:0] x_base;
    logic [aw-1:0] p_base;
    logic [6:0]    n;
    logic          acc;
  } cfg_t;

  function automatic inst_t idle_word();
    inst_t w;
    w          = '0;
    w.cen_pmem = 1'b1;
    w.wen_pmem = 1'b1;
    w.cen_xmem = 1'b1;
    w.wen_xmem = 1'b1;
    return w;
  endfunction

  state_t        state_q, state_d;
  cfg_t          cfg_q, cfg_d;
  logic [6:0]    k_q, k_d;
  logic [6:0]    j_q, j_d;
  logic [IW-1:0] idle_q, idle_d;
  inst_t         inst_q, inst_d;
  logic          busy_q, done_q, err_q, err_d;
  logic          out_try, wr_d;

  // NOTE: every flop, including the captured config, is cleared by the async
  // reset so a mid-tile reset leaves nothing stale behind.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      k_q     <= '0;
      j_q     <= '0;
      idle_q  <= '0;
      inst_q  <= idle_word();
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      k_q     <= k_d;
      j_q     <= j_d;
      idle_q  <= idle_d;
      inst_q  <= inst_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      err_q   <= err_d;
    end
  end

  // The outputs are registered, so everything below describes the cycle that
  // follows the coming edge: next state first, then the word for that state.
  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    k_d     = k_q;
    j_d     = j_q;
    idle_d  = idle_q;
    err_d   = 1'b0;
    out_try = 1'b0;
    wr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_x == 7'd0 || n_x > N_MAX) begin
            err_d = 1'b1;
          end else begin
            cfg_d   = '{w_base: w_base, x_base: x_base, p_base: p_base,
                        n: n_x, acc: acc_cfg};
            state_d = W_RD;
            k_d     = '0;
            j_d     = '0;
            idle_d  = '0;
          end
        end
      end
      W_RD: begin
        k_d = k_q + 7'd1;
        if (k_q == 7'(col - 1)) begin
          state_d = W_FL;
          k_d     = '0;
        end
      end
      W_FL: state_d = W_LD;
      W_LD: begin
        k_d = k_q + 7'd1;
        if (k_q == 7'(col - 1)) begin
          state_d = W_GAP;
          k_d     = '0;
        end
      end
      W_GAP: begin
        k_d = k_q + 7'd1;
        if (k_q == 7'(col - 1)) begin
          state_d = X_RD;
          k_d     = '0;
        end
      end
      X_RD: begin
        k_d = k_q + 7'd1;
        if (k_q == cfg_q.n - 7'd1) begin
          state_d = X_FL;
          k_d     = '0;
        end
      end
      X_FL: state_d = X_EX;
      X_EX: begin
        k_d = k_q + 7'd1;
        if (k_q == cfg_q.n - 7'd1) begin
          state_d = OUT;
          k_d     = '0;
          out_try = 1'b1;
        end
      end
      OUT: begin
        if (j_q == cfg_q.n) begin
          state_d = DONE;
        end else if (idle_q == IW'(tmo)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          out_try = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A drain write is issued for the next cycle only when the FIFO has data.
    if (out_try) begin
      if (ofifo_valid) begin
        wr_d   = 1'b1;
        j_d    = j_q + 7'd1;
        idle_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    inst_d       = idle_word();
    // SRAM read data arrives one cycle late, so L0 is written the cycle after a read.
    inst_d.l0_wr = (state_q == W_RD) || (state_q == X_RD);
    case (state_d)
      W_RD: begin
        inst_d.cen_xmem = 1'b0;
        inst_d.a_xmem   = cfg_d.w_base + aw'(k_d);
      end
      X_RD: begin
        inst_d.cen_xmem = 1'b0;
        inst_d.a_xmem   = cfg_d.x_base + aw'(k_d);
      end
      W_LD: begin
        inst_d.l0_rd = 1'b1;
        inst_d.load  = 1'b1;
      end
      X_EX: begin
        inst_d.l0_rd   = 1'b1;
        inst_d.execute = 1'b1;
        inst_d.acc     = cfg_d.acc;
      end
      default: ;
    endcase
    if (wr_d) begin
      inst_d.ofifo_rd = 1'b1;
      inst_d.cen_pmem = 1'b0;
      inst_d.wen_pmem = 1'b0;
      inst_d.a_pmem   = cfg_d.p_base + aw'(j_q);
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_tile_seq.sv
// Directed bench for tile_seq: full tiles, address wrap, OUT stalls, illegal
// starts, OUT timeout and mid-tile reset, all against hand-derived cycle maps.
module tb_tile_seq;

  localparam logic [34:0] IDLE_WORD = 35'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] w_base, x_base, p_base;
  logic [6:0]  n_x;
  logic        acc_cfg;
  logic        ofifo_valid;
  logic [34:0] inst;
  logic        busy, done, err;

  int n_chk = 0;
  int n_bad = 0;

  tile_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .w_base     (w_base),
    .x_base     (x_base),
    .p_base     (p_base),
    .n_x        (n_x),
    .acc_cfg    (acc_cfg),
    .ofifo_valid(ofifo_valid),
    .inst       (inst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected word for cycle c of a tile with ofifo_valid held high throughout.
  function automatic logic [34:0] exp_word(input int c, input int n,
                                           input logic [10:0] wb, input logic [10:0] xb,
                                           input logic [10:0] pb, input logic acc);
    logic [34:0] w;
    w = IDLE_WORD;
    if (c >= 1 && c <= 8) begin
      w[19]   = 1'b0;
      w[17:7] = wb + 11'(c - 1);
    end
    if ((c >= 2 && c <= 9) || (c >= 27 && c <= 26 + n)) w[2] = 1'b1;
    if (c >= 10 && c <= 17) begin
      w[3] = 1'b1;
      w[0] = 1'b1;
    end
    if (c >= 26 && c <= 25 + n) begin
      w[19]   = 1'b0;
      w[17:7] = xb + 11'(c - 26);
    end
    if (c >= 27 + n && c <= 26 + 2*n) begin
      w[3]  = 1'b1;
      w[1]  = 1'b1;
      w[33] = acc;
    end
    if (c >= 27 + 2*n && c <= 26 + 3*n) begin
      w[32]    = 1'b0;
      w[31]    = 1'b0;
      w[6]     = 1'b1;
      w[30:20] = pb + 11'(c - 27 - 2*n);
    end
    return w;
  endfunction

  // Called at a negedge; returns just after the edge that samples start (cycle 1).
  task automatic kick(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                      input logic [6:0] n, input logic acc);
    w_base  = wb;
    x_base  = xb;
    p_base  = pb;
    n_x     = n;
    acc_cfg = acc;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_tile(input string name, input int n, input logic [10:0] wb,
                          input logic [10:0] xb, input logic [10:0] pb, input logic acc);
    int writes;
    writes = 0;
    kick(wb, xb, pb, 7'(n), acc);
    for (int c = 1; c <= 28 + 3*n; c++) begin
      @(negedge clk);
      check($sformatf("%s inst c%0d", name, c), inst, exp_word(c, n, wb, xb, pb, acc));
      check($sformatf("%s busy c%0d", name, c), busy, (c <= 27 + 3*n));
      check($sformatf("%s done c%0d", name, c), done, (c == 27 + 3*n));
      check($sformatf("%s err c%0d", name, c), err, 1'b0);
      if (inst[6]) writes++;
    end
    check($sformatf("%s write count", name), writes, n);
  endtask

  task automatic illegal_start(input logic [6:0] n);
    n_x   = n;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check($sformatf("illegal n=%0d err", n), err, 1'b1);
    check($sformatf("illegal n=%0d busy", n), busy, 1'b0);
    check($sformatf("illegal n=%0d inst", n), inst, IDLE_WORD);
    @(negedge clk);
    check($sformatf("illegal n=%0d err pulse", n), err, 1'b0);
    check($sformatf("illegal n=%0d busy after", n), busy, 1'b0);
    check($sformatf("illegal n=%0d inst after", n), inst, IDLE_WORD);
  endtask

  initial begin
    int writes, done_cnt, err_cnt, err_cycle;
    reset       = 1'b0;
    start       = 1'b0;
    w_base      = '0;
    x_base      = '0;
    p_base      = '0;
    n_x         = 7'd1;
    acc_cfg     = 1'b0;
    ofifo_valid = 1'b1;

    #12;
    check("reset inst", inst, IDLE_WORD);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Basic tile, N=4: done in cycle 39.
    run_tile("t4", 4, 11'h000, 11'h010, 11'h020, 1'b0);

    illegal_start(7'd0);
    illegal_start(7'd65);

    // N=3, valid seen at the OUT edges as 1,0,1,0,1: writes in 33,35,37, done in 38.
    kick(11'h100, 11'h200, 11'h7FF, 7'd3, 1'b1);
    for (int c = 1; c <= 39; c++) begin
      @(negedge clk);
      if (c >= 33) begin
        check($sformatf("stall wr c%0d", c), inst[6], (c == 33 || c == 35 || c == 37));
        check($sformatf("stall done c%0d", c), done, (c == 38));
      end
      if (c == 33) check("stall addr 1", inst[30:20], 11'h7FF);
      if (c == 35) check("stall addr 2", inst[30:20], 11'h000);
      if (c == 37) check("stall addr 3", inst[30:20], 11'h001);
      if (c == 38) check("stall busy in done", busy, 1'b1);
      if (c == 39) check("stall busy after", busy, 1'b0);
      ofifo_valid = !(c == 33 || c == 35);
    end
    ofifo_valid = 1'b1;

    // Timeout, N=2, valid never high: OUT spans 31..285, err in 286. Start at 100 ignored.
    ofifo_valid = 1'b0;
    writes = 0; done_cnt = 0; err_cnt = 0; err_cycle = 0;
    kick(11'h000, 11'h010, 11'h020, 7'd2, 1'b0);
    for (int c = 1; c <= 290; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (err) begin
        err_cnt++;
        err_cycle = c;
      end
      if (inst[6]) writes++;
      if (c == 285) check("tmo busy before", busy, 1'b1);
      if (c == 286) begin
        check("tmo busy at err", busy, 1'b0);
        check("tmo inst at err", inst, IDLE_WORD);
      end
      if (c == 290) check("tmo stays idle", busy, 1'b0);
      if (c == 100) begin
        n_x   = 7'd5;
        start = 1'b1;
      end
      if (c == 101) start = 1'b0;
    end
    check("tmo err cycle", err_cycle, 286);
    check("tmo err count", err_cnt, 1);
    check("tmo done count", done_cnt, 0);
    check("tmo writes", writes, 0);
    ofifo_valid = 1'b1;

    // Reset in cycle 12 (W_LD), then a full tile after release.
    kick(11'h040, 11'h050, 11'h060, 7'd4, 1'b0);
    for (int c = 1; c <= 12; c++) @(negedge clk);
    check("mid load c12", inst[0], 1'b1);
    check("mid busy c12", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid rst inst", inst, IDLE_WORD);
    check("mid rst busy", busy, 1'b0);
    check("mid rst done", done, 1'b0);
    check("mid rst err", err, 1'b0);
    @(negedge clk);
    check("mid rst held inst", inst, IDLE_WORD);
    reset = 1'b1;
    run_tile("post_rst", 4, 11'h040, 11'h050, 11'h060, 1'b0);

    // Largest tile with weight and activation address wrap: done in cycle 219.
    run_tile("t64", 64, 11'h7FC, 11'h7F0, 11'h100, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
